// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI frame sequencer.
// Contents: sequencer state encoding, default gap/watchdog cycle counts,
// SPI byte width, and a helper that sizes a saturating counter.
package spi_seq_pkg;

  localparam int SPI_BYTE_W         = 8;
  localparam int DEF_GAP_CYCLES     = 100;
  localparam int DEF_TIMEOUT_CYCLES = 2000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_XFER    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4,
    ST_FIN     = 3'd5
  } seq_state_e;

  // Bits needed to hold values 0..max_val; never less than one bit so a
  // zero-length gap still yields a legal counter declaration.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable saturating down-counter with a zero flag.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset (counter clears to 0)
//   load_i     - load load_val_i this cycle (wins over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one, holding at zero
//   zero_o     - counter currently equals zero
module spi_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_frame_sequencer.sv
// Multi-byte frame controller feeding a byte-level SPI master.
// Accepts a frame request of FRAME_LEN bytes, pulls TX bytes over a
// valid/ready stream, runs the master's per-byte START/END handshake,
// returns each received byte as a one-cycle pulse, spaces bytes by
// GAP_CYCLES idle cycles and aborts on a watchdog expiry.
// Ports:
//   CLK, RST_N                 - clock, async active-low reset
//   FRAME_START, FRAME_LEN     - frame request (sampled in IDLE only)
//   BUSY, DONE, ERR            - frame status (DONE pulse, ERR sticky)
//   TX_DATA, TX_VALID, TX_READY - byte source stream (ready only in LOAD)
//   RX_DATA, RX_VALID          - received byte and its one-cycle strobe
//   SPI_START_N, SPI_TX        - to master: run byte (low), byte to send
//   SPI_RX, SPI_END            - from master: received byte, byte done
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int LEN_W          = 4,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FRAME_START,
  input  logic [LEN_W-1:0]      FRAME_LEN,
  output logic                  BUSY,
  input  logic [SPI_BYTE_W-1:0] TX_DATA,
  input  logic                  TX_VALID,
  output logic                  TX_READY,
  output logic [SPI_BYTE_W-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  SPI_START_N,
  output logic [SPI_BYTE_W-1:0] SPI_TX,
  input  logic [SPI_BYTE_W-1:0] SPI_RX,
  input  logic                  SPI_END
);

  localparam int WD_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  // Loading N-1 and stepping until zero spans exactly N cycles.
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  seq_state_e            state_q, state_d;
  logic [LEN_W-1:0]      bytes_left_q, bytes_left_d;
  logic                  err_q, err_d;
  logic                  start_n_q, start_n_d;
  logic [SPI_BYTE_W-1:0] spi_tx_q, spi_tx_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;

  logic wd_load, wd_dec, wd_zero;
  logic gap_load, gap_dec, gap_zero;

  spi_seq_timer #(.W(WD_W)) u_wd_timer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .dec_i      (wd_dec),
    .zero_o     (wd_zero)
  );

  spi_seq_timer #(.W(GAP_W)) u_gap_timer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    err_d        = err_q;
    start_n_d    = start_n_q;
    spi_tx_d     = spi_tx_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    wd_load      = 1'b0;
    wd_dec       = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (FRAME_START) begin
          if (FRAME_LEN != '0) begin
            bytes_left_d = FRAME_LEN;
            err_d        = 1'b0;
            state_d      = ST_LOAD;
          end else begin
            // Empty frame is a caller error: report it without touching SPI.
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_LOAD: begin
        if (TX_VALID) begin
          spi_tx_d  = TX_DATA;
          start_n_d = 1'b0;
          wd_load   = 1'b1;
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        wd_dec = 1'b1;
        // A completed byte beats a same-cycle watchdog expiry.
        if (SPI_END) begin
          rx_data_d  = SPI_RX;
          rx_valid_d = 1'b1;
          start_n_d  = 1'b1;
          if (bytes_left_q != '0) begin
            bytes_left_d = bytes_left_q - 1'b1;
          end
          wd_load = 1'b1;
          state_d = ST_RELEASE;
        end else if (wd_zero) begin
          start_n_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_FIN;
        end
      end
      ST_RELEASE: begin
        wd_dec = 1'b1;
        if (!SPI_END) begin
          if (bytes_left_q == '0) begin
            state_d = ST_FIN;
          end else if (GAP_CYCLES == 0) begin
            state_d = ST_LOAD;
          end else begin
            gap_load = 1'b1;
            state_d  = ST_GAP;
          end
        end else if (wd_zero) begin
          start_n_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_FIN;
        end
      end
      ST_GAP: begin
        gap_dec = 1'b1;
        if (gap_zero) begin
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      bytes_left_q <= '0;
      err_q        <= 1'b0;
      start_n_q    <= 1'b1;
      spi_tx_q     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      err_q        <= err_d;
      start_n_q    <= start_n_d;
      spi_tx_q     <= spi_tx_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  // Status outputs decode the state directly so they follow an
  // asynchronous reset in the same cycle.
  assign BUSY        = (state_q != ST_IDLE);
  assign TX_READY    = (state_q == ST_LOAD);
  assign DONE        = (state_q == ST_FIN);
  assign ERR         = err_q;
  assign SPI_START_N = start_n_q;
  assign SPI_TX      = spi_tx_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Self-checking bench for spi_frame_sequencer.
// A cycle-stepped SPI master model, a TX byte source and a per-cycle
// compare against expected RX bytes and frame status all advance inside
// tick(), so every bench variable has a single writer.
module tb_spi_frame_sequencer;

  localparam int LEN_W    = 4;
  localparam int GAP      = 100;
  localparam int TMO      = 2000;
  localparam int BYTE_CYC = 40;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             FRAME_START = 1'b0;
  logic [LEN_W-1:0] FRAME_LEN = '0;
  logic             BUSY;
  logic [7:0]       TX_DATA = 8'h00;
  logic             TX_VALID = 1'b0;
  logic             TX_READY;
  logic [7:0]       RX_DATA;
  logic             RX_VALID;
  logic             DONE;
  logic             ERR;
  logic             SPI_START_N;
  logic [7:0]       SPI_TX;
  logic [7:0]       SPI_RX = 8'h00;
  logic             SPI_END = 1'b0;

  spi_frame_sequencer #(
    .LEN_W          (LEN_W),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FRAME_START (FRAME_START),
    .FRAME_LEN   (FRAME_LEN),
    .BUSY        (BUSY),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .DONE        (DONE),
    .ERR         (ERR),
    .SPI_START_N (SPI_START_N),
    .SPI_TX      (SPI_TX),
    .SPI_RX      (SPI_RX),
    .SPI_END     (SPI_END)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model: expected RX bytes in order, expected ERR at DONE.
  logic [7:0] exp_mem [64];
  int         exp_wr = 0, exp_rd = 0;
  logic       exp_err = 1'b0;
  logic [7:0] last_rx = 8'h00;
  logic       prev_done = 1'b0;

  // TX source.
  logic [7:0] tx_mem [32];
  int         tx_wr = 0, tx_rd = 0, hs_cnt = 0;
  logic       tx_hold = 1'b0;
  logic       hs = 1'b0;

  // SPI master model.
  logic [7:0] m_mem [32];
  int         m_wr = 0, m_rd = 0;
  int         m_st = 0, m_cnt = 0;
  logic       m_respond = 1'b1;
  logic       mosi_mem [256];
  int         mosi_wr = 0;

  // Event monitor.
  logic prev_sn = 1'b1;
  logic have_rise = 1'b0;
  int   rise_cyc = 0, fall_cyc = 0, fall_cnt = 0;
  int   gap_mem [64];
  int   gap_wr = 0;
  int   done_cnt = 0, done_cyc = 0, rx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    if (!RST_N) begin
      prev_sn   = 1'b1;
      last_rx   = 8'h00;
      prev_done = 1'b0;
    end else begin
      if (RX_VALID) begin
        rx_cnt++;
        if (exp_rd < exp_wr) begin
          check("rx_data", RX_DATA, exp_mem[exp_rd]);
          last_rx = exp_mem[exp_rd];
          exp_rd++;
        end else begin
          check("rx_unexpected", RX_VALID, 1'b0);
        end
      end else begin
        check("rx_hold", RX_DATA, last_rx);
      end
      check("ready_without_busy", TX_READY && !BUSY, 1'b0);
      check("start_without_busy", !SPI_START_N && !BUSY, 1'b0);
      if (DONE) begin
        check("done_err", ERR, exp_err);
        check("done_one_cycle", prev_done, 1'b0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = DONE;
      if (prev_sn && !SPI_START_N) begin
        fall_cnt++;
        fall_cyc = cyc;
        if (have_rise) begin
          gap_mem[gap_wr] = cyc - rise_cyc;
          gap_wr++;
        end
      end
      if (!prev_sn && SPI_START_N) begin
        rise_cyc  = cyc;
        have_rise = 1'b1;
      end
      prev_sn = SPI_START_N;
    end
    hs = TX_VALID && TX_READY;
    @(posedge CLK);
    cyc++;
    #1;
    // TX source
    if (!RST_N) begin
      TX_VALID = 1'b0;
    end else begin
      if (hs) begin
        tx_rd++;
        hs_cnt++;
      end
      TX_VALID = (tx_rd < tx_wr) && !tx_hold;
      TX_DATA  = (tx_rd < tx_wr) ? tx_mem[tx_rd] : 8'h00;
    end
    // SPI master: MSB first, END raised after BYTE_CYC, dropped one cycle
    // after START_N is seen high again.
    if (!RST_N) begin
      m_st    = 0;
      SPI_END = 1'b0;
    end else begin
      case (m_st)
        0: if (!SPI_START_N) begin
          for (int b = 7; b >= 0; b--) begin
            mosi_mem[mosi_wr] = SPI_TX[b];
            mosi_wr++;
          end
          m_cnt = BYTE_CYC;
          m_st  = 1;
        end
        1: begin
          if (SPI_START_N) begin
            m_st = 0;
          end else if (m_cnt > 1) begin
            m_cnt--;
          end else if (m_respond) begin
            SPI_RX  = m_mem[m_rd];
            m_rd++;
            SPI_END = 1'b1;
            m_st    = 2;
          end
        end
        2: if (SPI_START_N) m_st = 3;
        default: begin
          SPI_END = 1'b0;
          m_st    = 0;
        end
      endcase
    end
  endtask

  task automatic start_frame(input int len);
    FRAME_LEN   = LEN_W'(len);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] tx, input logic [7:0] rx);
    tx_mem[tx_wr] = tx; tx_wr++;
    m_mem[m_wr]   = rx; m_wr++;
    exp_mem[exp_wr] = rx; exp_wr++;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0, i;
    d0 = done_cnt; i = 0;
    while (done_cnt == d0 && i < budget) begin tick(); i++; end
    check({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (rx_cnt < target && i < budget) begin tick(); i++; end
    check({tag, "_rx_reached"}, rx_cnt >= target, 1'b1);
  endtask

  task automatic wait_fall(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (fall_cnt < target && i < budget) begin tick(); i++; end
    check({tag, "_start_fell"}, fall_cnt >= target, 1'b1);
  endtask

  initial begin
    int r0, h0, f0, g0, mb, low_cyc, d0;
    logic exp_seq [8];
    logic [7:0] got;

    // Reset values
    repeat (3) tick();
    check("rst_start_n", SPI_START_N, 1'b1);
    check("rst_spi_tx", SPI_TX, 8'h00);
    check("rst_rx_data", RX_DATA, 8'h00);
    check("rst_rx_valid", RX_VALID, 1'b0);
    check("rst_tx_ready", TX_READY, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_err", ERR, 1'b0);
    RST_N = 1'b1;
    repeat (2) tick();

    // Single byte: 0xA5 out, 0x3C back
    exp_err = 1'b0;
    push_byte(8'hA5, 8'h3C);
    r0 = rx_cnt; mb = mosi_wr; h0 = hs_cnt;
    start_frame(1);
    check("t1_busy_after_accept", BUSY, 1'b1);
    check("t1_ready_after_accept", TX_READY, 1'b1);
    wait_done(300, "t1");
    check("t1_rx_count", rx_cnt - r0, 1);
    check("t1_hs_count", hs_cnt - h0, 1);
    check("t1_err", ERR, 1'b0);
    check("t1_busy_after_done", BUSY, 1'b0);
    check("t1_rx_data_held", RX_DATA, 8'h3C);
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) check($sformatf("t1_mosi_bit%0d", i), mosi_mem[mb + i], exp_seq[i]);

    // Three bytes with gap; a second FRAME_START mid-frame is ignored
    push_byte(8'h01, 8'h81);
    push_byte(8'h02, 8'h82);
    push_byte(8'h03, 8'h83);
    r0 = rx_cnt; h0 = hs_cnt; f0 = fall_cnt; d0 = done_cnt;
    start_frame(3);
    wait_fall(f0 + 1, 10, "t2");
    g0 = gap_wr;
    wait_rx(r0 + 1, 200, "t2");
    start_frame(5);
    wait_done(1000, "t2");
    check("t2_rx_count", rx_cnt - r0, 3);
    check("t2_hs_count", hs_cnt - h0, 3);
    check("t2_fall_count", fall_cnt - f0, 3);
    check("t2_gap_count", gap_wr - g0, 2);
    for (int i = g0; i < gap_wr; i++) check("t2_gap_min", gap_mem[i] >= GAP + 1, 1'b1);
    check("t2_err", ERR, 1'b0);
    repeat (5) tick();
    check("t2_single_done", done_cnt - d0, 1);

    // TX starvation between byte 1 and byte 2
    push_byte(8'h11, 8'h91);
    m_mem[m_wr] = 8'h92; m_wr++;
    exp_mem[exp_wr] = 8'h92; exp_wr++;
    r0 = rx_cnt; d0 = done_cnt;
    start_frame(2);
    wait_rx(r0 + 1, 200, "t3");
    low_cyc = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (!SPI_START_N) low_cyc++;
    end
    check("t3_start_n_held_high", low_cyc, 0);
    check("t3_no_done_while_starved", done_cnt - d0, 0);
    check("t3_waiting_in_load", TX_READY, 1'b1);
    tx_mem[tx_wr] = 8'h12; tx_wr++;
    wait_done(400, "t3");
    check("t3_rx_count", rx_cnt - r0, 2);
    check("t3_err", ERR, 1'b0);

    // Zero-length frame
    exp_err = 1'b1;
    f0 = fall_cnt;
    start_frame(0);
    check("t4_done", DONE, 1'b1);
    check("t4_err", ERR, 1'b1);
    repeat (4) tick();
    check("t4_no_spi", fall_cnt - f0, 0);
    check("t4_busy", BUSY, 1'b0);

    // Watchdog: master never ends the byte
    m_respond = 1'b0;
    tx_mem[tx_wr] = 8'hC3; tx_wr++;
    r0 = rx_cnt; f0 = fall_cnt;
    start_frame(1);
    check("t5_err_cleared", ERR, 1'b0);
    wait_fall(f0 + 1, 10, "t5");
    wait_done(TMO + 50, "t5");
    check("t5_done_latency", done_cyc - fall_cyc, TMO);
    check("t5_no_rx", rx_cnt - r0, 0);
    check("t5_err", ERR, 1'b1);
    check("t5_start_n_high", SPI_START_N, 1'b1);
    m_respond = 1'b1;

    // Reset in the middle of a byte, then a clean frame
    exp_err = 1'b0;
    m_mem[m_wr] = 8'h77; m_wr++;
    tx_mem[tx_wr] = 8'h5A; tx_wr++;
    f0 = fall_cnt;
    start_frame(1);
    wait_fall(f0 + 1, 10, "t6");
    repeat (10) tick();
    #2 RST_N = 1'b0;
    #1;
    check("t6_rst_start_n", SPI_START_N, 1'b1);
    check("t6_rst_busy", BUSY, 1'b0);
    check("t6_rst_err", ERR, 1'b0);
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (2) tick();
    exp_mem[exp_wr] = 8'h77; exp_wr++;
    tx_mem[tx_wr] = 8'h96; tx_wr++;
    r0 = rx_cnt; mb = mosi_wr;
    start_frame(1);
    wait_done(300, "t6");
    check("t6_rx_count", rx_cnt - r0, 1);
    check("t6_err", ERR, 1'b0);
    got = '0;
    for (int i = 0; i < 8; i++) got = {got[6:0], mosi_mem[mb + i]};
    check("t6_mosi_byte", got, 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
